// File: rtl/i2c_master_byte_tx_if.sv
// ---------------------------------------------------------------------------
// i2c_master_byte_tx_if
// Request/status bundle between a client and the i2c_master_byte_tx engine.
//   modport slave  : the bit engine (accepts requests, reports status)
//   modport master : the requesting client
// Client -> engine : i_start, i_addr[6:0], i_rw, i_wdata[7:0]
// Engine -> client : o_busy, o_done, o_ack_err, o_rdata[7:0]
// The I2C bus pins (SCL, SDA) stay plain ports on the engine because SDA
// is an open-drain inout.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface i2c_master_byte_tx_if;
    logic       i_start;
    logic [6:0] i_addr;
    logic       i_rw;
    logic [7:0] i_wdata;
    logic       o_busy;
    logic       o_done;
    logic       o_ack_err;
    logic [7:0] o_rdata;

    modport slave (
        input  i_start, i_addr, i_rw, i_wdata,
        output o_busy, o_done, o_ack_err, o_rdata
    );

    modport master (
        output i_start, i_addr, i_rw, i_wdata,
        input  o_busy, o_done, o_ack_err, o_rdata
    );
endinterface

// File: rtl/i2c_master_byte_tx.sv
// ---------------------------------------------------------------------------
// i2c_master_byte_tx
// I2C master bit engine. One request produces START, 7-bit address + R/W,
// address ACK, one data byte, data ACK phase and STOP.
// SCL is derived from i_clk by a quarter-period tick divider: every bit is
// four quarters q0..q3 (SCL low in q0/q1, high in q2/q3), SDA changes on
// entry to q0 and is sampled on the tick that enters q2 (SCL rise).
//
// Parameters
//   CLK_DIV    i_clk cycles per quarter-period tick (>= 2)
// Ports
//   i_clk      clock
//   i_reset    asynchronous, active-high reset (aborts without STOP)
//   ctrl       request/status interface (slave modport):
//                i_start, i_addr, i_rw, i_wdata -> o_busy, o_done,
//                o_ack_err, o_rdata
//   o_scl      SCL, push-pull, idle high
//   io_sda     SDA, open-drain: driven 0 or released to 'z
// Build option
//   I2C_MASTER_READ_EN  when defined, i_rw=1 turns the data phase into a
//                       read into o_rdata; when undefined the R/W bit is
//                       forced to 0 and o_rdata is tied to 0.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module i2c_master_byte_tx #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    i2c_master_byte_tx_if.slave  ctrl,
    output logic                 o_scl,
    inout  wire                  io_sda
);

    localparam int unsigned      DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

`ifdef I2C_MASTER_READ_EN
    localparam logic READ_EN = 1'b1;
`else
    localparam logic READ_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_A_ACK,
        S_DATA,
        S_D_ACK,
        S_STOP,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [2:0]       bit_q, bit_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       addr_byte_q, addr_byte_d;  // {addr, rw}
    logic [7:0]       wdata_q, wdata_d;
    logic             ack_err_q, ack_err_d;
    logic             scl_q, scl_d;
    logic             sda_low_q, sda_low_d;
`ifdef I2C_MASTER_READ_EN
    logic [7:0]       rx_q, rx_d;
    logic [7:0]       rdata_q, rdata_d;
`endif

    logic busy;
    logic tick;
    logic sample_tick;
    logic phase_end;
    logic reading;
    logic sda_in;

    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign tick        = busy && (div_q == DIV_LAST);
    assign sample_tick = tick && (qtr_q == 2'd1);  // tick entering q2
    assign phase_end   = tick && (qtr_q == 2'd3);
    assign reading     = addr_byte_q[0];           // always 0 without read support
    assign sda_in      = io_sda;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        qtr_d       = qtr_q;
        bit_d       = bit_q;
        div_d       = '0;
        addr_byte_d = addr_byte_q;
        wdata_d     = wdata_q;
        ack_err_d   = ack_err_q;
`ifdef I2C_MASTER_READ_EN
        rx_d        = rx_q;
        rdata_d     = rdata_q;
`endif
        scl_d       = 1'b1;
        sda_low_d   = 1'b0;

        if (busy) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick) begin
                qtr_d = qtr_q + 2'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (ctrl.i_start) begin
                    addr_byte_d = {ctrl.i_addr, ctrl.i_rw & READ_EN};
                    wdata_d     = ctrl.i_wdata;
                    ack_err_d   = 1'b0;
                    qtr_d       = 2'd0;
                    bit_d       = 3'd7;
                    state_d     = S_START;
                end
            end
            S_START: begin
                if (phase_end) begin
                    bit_d   = 3'd7;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (phase_end) begin
                    if (bit_q == 3'd0) begin
                        state_d = S_A_ACK;
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            S_A_ACK: begin
                if (sample_tick && sda_in) begin
                    ack_err_d = 1'b1;
                end
                if (phase_end) begin
                    // ack_err_q was set by this phase's sample, so it marks an address NACK.
                    bit_d   = 3'd7;
                    state_d = ack_err_q ? S_STOP : S_DATA;
                end
            end
            S_DATA: begin
`ifdef I2C_MASTER_READ_EN
                if (sample_tick && reading) begin
                    rx_d = {rx_q[6:0], sda_in};
                end
                if (phase_end && (bit_q == 3'd0) && reading) begin
                    rdata_d = rx_q;
                end
`endif
                if (phase_end) begin
                    if (bit_q == 3'd0) begin
                        state_d = S_D_ACK;
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            S_D_ACK: begin
                // On a read the master NACKs by releasing SDA; only writes check the slave.
                if (sample_tick && !reading && sda_in) begin
                    ack_err_d = 1'b1;
                end
                if (phase_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (phase_end) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // A request in this cycle is deliberately not looked at.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Bus levels are a function of the position being entered, so the
        // registered pins change on the same edge as the quarter.
        case (state_d)
            S_START: begin
                scl_d     = (qtr_d != 2'd3);
                sda_low_d = qtr_d[1];
            end
            S_ADDR: begin
                scl_d     = qtr_d[1];
                sda_low_d = ~addr_byte_q[bit_d];
            end
            S_A_ACK, S_D_ACK: begin
                scl_d = qtr_d[1];
            end
            S_DATA: begin
                scl_d     = qtr_d[1];
                sda_low_d = ~reading & ~wdata_q[bit_d];
            end
            S_STOP: begin
                scl_d     = (qtr_d != 2'd0);
                sda_low_d = ~qtr_d[1];
            end
            default: begin
                scl_d     = 1'b1;
                sda_low_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            qtr_q       <= 2'd0;
            bit_q       <= 3'd0;
            div_q       <= '0;
            addr_byte_q <= 8'h00;
            wdata_q     <= 8'h00;
            ack_err_q   <= 1'b0;
            scl_q       <= 1'b1;
            sda_low_q   <= 1'b0;
`ifdef I2C_MASTER_READ_EN
            rx_q        <= 8'h00;
            rdata_q     <= 8'h00;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            qtr_q       <= qtr_d;
            bit_q       <= bit_d;
            div_q       <= div_d;
            addr_byte_q <= addr_byte_d;
            wdata_q     <= wdata_d;
            ack_err_q   <= ack_err_d;
            scl_q       <= scl_d;
            sda_low_q   <= sda_low_d;
`ifdef I2C_MASTER_READ_EN
            rx_q        <= rx_d;
            rdata_q     <= rdata_d;
`endif
        end
    end

    assign o_scl  = scl_q;
    assign io_sda = sda_low_q ? 1'b0 : 1'bz;

    assign ctrl.o_busy    = busy;
    assign ctrl.o_done    = (state_q == S_DONE);
    assign ctrl.o_ack_err = ack_err_q;
`ifdef I2C_MASTER_READ_EN
    assign ctrl.o_rdata   = rdata_q;
`else
    assign ctrl.o_rdata   = 8'h00;
`endif

endmodule

// File: tb/tb_i2c_master_byte_tx.sv
// ---------------------------------------------------------------------------
// tb_i2c_master_byte_tx
// Self-checking bench for i2c_master_byte_tx. A bus monitor decodes START,
// STOP and every SCL rise; a behavioural slave answers by SCL-fall count.
// Expected frames, error flags and latencies come from a transaction-level
// model of the I2C byte frame.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_master_byte_tx;

    localparam int CLK_DIV = 4;
    localparam int LIMIT   = 2000;

`ifdef I2C_MASTER_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
        bit         ack_addr;   // slave acknowledges its address
        bit         ack_data;   // slave acknowledges the written byte
        logic [7:0] sdata;      // byte the slave returns on a read
        bit         exp_err;
        int         exp_ticks;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    wire  scl;
    wire  sda;

    pullup (sda);

    logic slv_low = 1'b0;
    assign sda = slv_low ? 1'b0 : 1'bz;

    i2c_master_byte_tx_if ctrl ();

    i2c_master_byte_tx #(.CLK_DIV(CLK_DIV)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .ctrl    (ctrl),
        .o_scl   (scl),
        .io_sda  (sda)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- bus monitor + behavioural slave ----------------
    bit         cur_ack_addr = 1'b0;
    bit         cur_ack_data = 1'b0;
    bit         cur_rw       = 1'b0;
    logic [7:0] cur_sdata    = 8'h00;

    logic prev_scl = 1'b1;
    logic prev_sda = 1'b1;
    logic now_scl;
    logic now_sda;
    int   start_cnt = 0;
    int   stop_cnt  = 0;
    int   slv_cnt   = 0;
    logic bits_q[$];

    // SCL falls after START are numbered 0..: 0-7 address bits, 8 address
    // ACK, 9-16 data bits, 17 data ACK, 18 the STOP low phase.
    function automatic logic slave_drive(int c);
        if (c == 8)             return cur_ack_addr;
        if (c >= 9 && c <= 16)  return cur_ack_addr && cur_rw && !cur_sdata[16 - c];
        if (c == 17)            return cur_ack_addr && !cur_rw && cur_ack_data;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        now_scl = scl;
        now_sda = sda;
        if (prev_scl && now_scl && prev_sda && !now_sda) begin
            start_cnt++;
            bits_q.delete();
            slv_cnt = -1;
            slv_low = 1'b0;
        end else if (prev_scl && now_scl && !prev_sda && now_sda) begin
            stop_cnt++;
        end
        if (!prev_scl && now_scl) bits_q.push_back(now_sda);
        if (prev_scl && !now_scl) begin
            slv_cnt++;
            slv_low = slave_drive(slv_cnt);
        end
        prev_scl = now_scl;
        prev_sda = now_sda;
    end

    // ---------------- transaction-level reference model ----------------
    logic [7:0] model_rdata = 8'h00;

    function automatic vec_t model(input vec_t v);
        bit rw;
        rw          = v.rw & READ_EN;
        v.exp_err   = !v.ack_addr || (!rw && !v.ack_data);
        // START + 8 addr + ACK (+ 8 data + ACK) + STOP, four ticks per bit
        v.exp_ticks = v.ack_addr ? 20 * 4 : 11 * 4;
        return v;
    endfunction

    // SDA seen at each SCL rise, including the rise inside STOP (SDA low).
    task automatic build_bits(input vec_t v, output logic [31:0] pk, output int n);
        bit         rw;
        logic [7:0] a;
        logic [7:0] d;
        rw = v.rw & READ_EN;
        a  = {v.addr, rw};
        d  = rw ? v.sdata : v.wdata;
        pk = '0;
        n  = 0;
        for (int i = 7; i >= 0; i--) begin pk = {pk[30:0], a[i]}; n++; end
        pk = {pk[30:0], ~v.ack_addr}; n++;
        if (v.ack_addr) begin
            for (int i = 7; i >= 0; i--) begin pk = {pk[30:0], d[i]}; n++; end
            pk = {pk[30:0], rw ? 1'b1 : ~v.ack_data}; n++;
        end
        pk = {pk[30:0], 1'b0}; n++;
    endtask

    // ---------------- drivers ----------------
    task automatic set_slave(input vec_t v);
        cur_ack_addr = v.ack_addr;
        cur_ack_data = v.ack_data;
        cur_rw       = v.rw & READ_EN;
        cur_sdata    = v.sdata;
    endtask

    task automatic apply_req(input vec_t v);
        ctrl.i_addr  = v.addr;
        ctrl.i_rw    = v.rw;
        ctrl.i_wdata = v.wdata;
        ctrl.i_start = 1'b1;
    endtask

    task automatic launch(input vec_t v);
        set_slave(v);
        @(negedge clk);
        apply_req(v);
        @(posedge clk);
        #1 ctrl.i_start = 1'b0;
    endtask

    // Called just after the accepting edge; returns at the o_done sample.
    task automatic finish_txn(input vec_t v, input bit mid_pulse);
        int          cyc;
        bit          seen;
        int          base_start;
        int          base_stop;
        int          exp_n;
        logic [31:0] exp_bits;
        logic [31:0] act_bits;
        base_start = start_cnt;
        base_stop  = stop_cnt;
        cyc        = 0;
        seen       = 1'b0;
        build_bits(v, exp_bits, exp_n);
        if ((v.rw & READ_EN) && v.ack_addr) model_rdata = v.sdata;
        while (!seen && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("busy_after_accept", ctrl.o_busy, 1);
            if (mid_pulse && cyc == 40) begin
                ctrl.i_addr  = ~v.addr;
                ctrl.i_wdata = ~v.wdata;
                ctrl.i_start = 1'b1;
            end
            if (mid_pulse && cyc == 41) ctrl.i_start = 1'b0;
            if (ctrl.o_done) seen = 1'b1;
        end
        check("latency_cycles", seen ? cyc : 0, v.exp_ticks * CLK_DIV + 1);
        check("ack_err", ctrl.o_ack_err, v.exp_err);
        check("busy_at_done", ctrl.o_busy, 0);
        check("rdata", ctrl.o_rdata, model_rdata);
        check("start_edges", start_cnt - base_start, 1);
        check("stop_edges", stop_cnt - base_stop, 1);
        act_bits = '0;
        foreach (bits_q[i]) act_bits = {act_bits[30:0], bits_q[i]};
        check("bit_count", bits_q.size(), exp_n);
        check("bit_values", act_bits, exp_bits);
    endtask

    task automatic run_txn(input vec_t v);
        launch(v);
        finish_txn(v, 1'b0);
        @(negedge clk);
        check("done_one_cycle", ctrl.o_done, 0);
    endtask

    // ---------------- test sequence ----------------
    vec_t tbl[5];
    vec_t v;
    vec_t v2;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ctrl.i_start = 1'b0;
        ctrl.i_addr  = 7'h00;
        ctrl.i_rw    = 1'b0;
        ctrl.i_wdata = 8'h00;

        //            addr   rw    wdata  ackA  ackD  sdata  err   ticks
        tbl[0] = '{7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 80};
        tbl[1] = '{7'h50, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b1, 44};
        tbl[2] = '{7'h2A, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b1, 80};
        tbl[3] = '{7'h7F, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 80};
        tbl[4] = '{7'h00, 1'b0, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0, 80};

        // Reset held three cycles
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_scl", scl, 1);
        check("rst_sda_released", sda, 1);
        check("rst_busy", ctrl.o_busy, 0);
        check("rst_done", ctrl.o_done, 0);
        check("rst_ack_err", ctrl.o_ack_err, 0);
        check("rst_rdata", ctrl.o_rdata, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", ctrl.o_busy, 0);
        check("idle_scl", scl, 1);

        // Table vectors: nominal write, address NACK, data NACK, edge bytes
        for (int i = 0; i < 5; i++) run_txn(tbl[i]);

        // Request pulsed in mid-ADDR is ignored
        v = model('{7'h1B, 1'b0, 8'h96, 1'b1, 1'b1, 8'h00, 1'b0, 0});
        launch(v);
        finish_txn(v, 1'b1);
        @(negedge clk);

        // Request in the o_done cycle is ignored, accepted one cycle later
        v  = model('{7'h33, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b0, 0});
        v2 = model('{7'h44, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00, 1'b0, 0});
        launch(v);
        finish_txn(v, 1'b0);
        set_slave(v2);
        apply_req(v2);
        @(posedge clk);
        @(negedge clk);
        check("done_cycle_start_ignored", ctrl.o_busy, 0);
        @(posedge clk);
        #1 ctrl.i_start = 1'b0;
        finish_txn(v2, 1'b0);
        @(negedge clk);

        // Async reset during DATA bit 3 (cycle 229 = tick 57)
        v = model('{7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 0});
        launch(v);
        repeat (229) @(negedge clk);
        check("busy_before_abort", ctrl.o_busy, 1);
        #1 rst = 1'b1;
        #1;
        check("abort_scl", scl, 1);
        check("abort_sda_released", sda, 1);
        check("abort_busy", ctrl.o_busy, 0);
        check("abort_done", ctrl.o_done, 0);
        check("abort_ack_err", ctrl.o_ack_err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_txn(v);

`ifdef I2C_MASTER_READ_EN
        // Read: slave returns 8'h3C, master NACKs
        v = model('{7'h50, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 0});
        run_txn(v);
`endif

        // Randomized requests checked against the model
        for (int i = 0; i < 8; i++) begin
            v.addr     = 7'($urandom);
            v.rw       = 1'($urandom);
            v.wdata    = 8'($urandom);
            v.ack_addr = ($urandom_range(0, 3) != 0);
            v.ack_data = 1'($urandom);
            v.sdata    = 8'($urandom);
            v          = model(v);
            run_txn(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
